isi_ms_decode: RTL and testbench

Bit-exact decoder and monitor for the ISI/MS element-selection outputs. It takes the B-path (18-element) and C-path (6-element) select/sign vectors and reconstructs the signed numbers they represent. It checks those numbers against the encoder inputs, delayed to match encoder latency, and reports per-cycle element-transition counts as an ISI activity metric. It sits beside the ISI/MS encoder in the DAC digital bench and the on-chip debug path, at the far end of the SV/ST element interface.

---
 rtl/isi_ms_pkg.sv | 20 ++
 rtl/elem_pop_dec.sv | 64 ++++++
 rtl/isi_ms_decode.sv | 121 ++++++++++++
 tb/tb_isi_ms_decode.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/isi_ms_pkg.sv
// Shared constants and the element-value mapping for the ISI/MS decoder.
package isi_ms_pkg;
  localparam int NB_ELEM = 18;
  localparam int NC_ELEM = 6;
  localparam int VB_W    = 6;
  localparam int VC_W    = 4;
  localparam int TRB_W   = 5;
  localparam int TRC_W   = 3;

  // One unit element: deselected contributes 0, selected contributes +1 or -1 by sign.
  function automatic logic signed [1:0] elem_val(input logic sv, input logic st);
    if (!sv) begin
      return 2'sd0;
    end else if (st) begin
      return 2'sd1;
    end else begin
      return -2'sd1;
    end
  endfunction
endpackage

// File: rtl/elem_pop_dec.sv
// One element path: registers the select/sign vectors with a previous-cycle copy,
// then registers the signed element sum and the count of toggled elements.
module elem_pop_dec #(
  parameter int N  = 18,
  parameter int OW = 6,
  parameter int TW = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         i_sv,
  input  logic [N-1:0]         i_st,
  output logic signed [OW-1:0] o_val,
  output logic [TW-1:0]        o_tr
);
  import isi_ms_pkg::*;

  logic [N-1:0]         r_sv_p1;
  logic [N-1:0]         r_st_p1;
  logic [N-1:0]         r_sv_prev_p1;
  logic [N-1:0]         r_st_prev_p1;
  logic signed [OW-1:0] r_val_p2;
  logic [TW-1:0]        r_tr_p2;
  logic signed [OW-1:0] w_val;
  logic [TW-1:0]        w_tr;

  // Stage 1: capture current vectors and keep the previous ones for transition detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sv_p1      <= '0;
      r_st_p1      <= '0;
      r_sv_prev_p1 <= '0;
      r_st_prev_p1 <= '0;
    end else begin
      r_sv_p1      <= i_sv;
      r_st_p1      <= i_st;
      r_sv_prev_p1 <= r_sv_p1;
      r_st_prev_p1 <= r_st_p1;
    end
  end

  // Signed element sum and toggle count; ST toggles count even on deselected elements.
  always_comb begin
    w_val = '0;
    w_tr  = '0;
    for (int i = 0; i < N; i++) begin
      w_val = w_val + OW'(elem_val(r_sv_p1[i], r_st_p1[i]));
      w_tr  = w_tr + TW'((r_sv_p1[i] ^ r_sv_prev_p1[i]) | (r_st_p1[i] ^ r_st_prev_p1[i]));
    end
  end

  // Stage 2: register the reconstructed value and transition count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_val_p2 <= '0;
      r_tr_p2  <= '0;
    end else begin
      r_val_p2 <= w_val;
      r_tr_p2  <= w_tr;
    end
  end

  assign o_val = r_val_p2;
  assign o_tr  = r_tr_p2;
endmodule

// File: rtl/isi_ms_decode.sv
// ISI/MS element-vector decoder and monitor: reconstructs B/C values, reports
// per-cycle element transitions, and checks against latency-aligned encoder inputs.
module isi_ms_decode
  import isi_ms_pkg::*;
#(
  parameter int ENC_LAT = 1,
  parameter int ERRW    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NB_ELEM-1:0]     SVB,
  input  logic [NB_ELEM-1:0]     STB,
  input  logic [NC_ELEM-1:0]     SVC,
  input  logic [NC_ELEM-1:0]     STC,
  input  logic signed [VB_W-1:0] VB,
  input  logic signed [VC_W-1:0] VC,
  input  logic                   chk_en,
  input  logic                   clr,
  output logic signed [VB_W-1:0] VB_rec,
  output logic signed [VC_W-1:0] VC_rec,
  output logic                   rec_valid,
  output logic [TRB_W-1:0]       TRB,
  output logic [TRC_W-1:0]       TRC,
  output logic                   err,
  output logic [ERRW-1:0]        err_cnt,
  output logic                   err_sticky
);
  // Reference path depth: encoder latency plus the two decode stages.
  localparam int         DLY      = ENC_LAT + 2;
  localparam logic [3:0] FILL_MAX = 4'(DLY);

  logic signed [VB_W-1:0] w_vb_rec;
  logic signed [VC_W-1:0] w_vc_rec;
  logic [TRB_W-1:0]       w_trb;
  logic [TRC_W-1:0]       w_trc;
  logic signed [VB_W-1:0] r_vb_dly [DLY];
  logic signed [VC_W-1:0] r_vc_dly [DLY];
  logic [3:0]             r_fill;
  logic                   r_err_p3;
  logic [ERRW-1:0]        r_err_cnt;
  logic                   r_err_sticky;
  logic                   w_rec_valid;
  logic                   w_err;

  elem_pop_dec #(.N(NB_ELEM), .OW(VB_W), .TW(TRB_W)) u_dec_b (
    .clk   (clk),
    .rstn  (rstn),
    .i_sv  (SVB),
    .i_st  (STB),
    .o_val (w_vb_rec),
    .o_tr  (w_trb)
  );

  elem_pop_dec #(.N(NC_ELEM), .OW(VC_W), .TW(TRC_W)) u_dec_c (
    .clk   (clk),
    .rstn  (rstn),
    .i_sv  (SVC),
    .i_st  (STC),
    .o_val (w_vc_rec),
    .o_tr  (w_trc)
  );

  // Reference delay line aligning VB/VC with the reconstructed values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DLY; i++) begin
        r_vb_dly[i] <= '0;
        r_vc_dly[i] <= '0;
      end
    end else begin
      r_vb_dly[0] <= VB;
      r_vc_dly[0] <= VC;
      for (int i = 1; i < DLY; i++) begin
        r_vb_dly[i] <= r_vb_dly[i-1];
        r_vc_dly[i] <= r_vc_dly[i-1];
      end
    end
  end

  // Fill counter: saturates once both the decode pipe and reference line hold real data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fill <= '0;
    end else if (r_fill != FILL_MAX) begin
      r_fill <= r_fill + 4'd1;
    end
  end

  assign w_rec_valid = (r_fill == FILL_MAX);
  assign w_err = chk_en & w_rec_valid &
                 ((w_vb_rec != r_vb_dly[DLY-1]) | (w_vc_rec != r_vc_dly[DLY-1]));

  // Stage 3: register mismatch; clr overrides counter/sticky update but not err itself.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err_p3     <= 1'b0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_p3 <= w_err;
      if (clr) begin
        r_err_cnt    <= '0;
        r_err_sticky <= 1'b0;
      end else if (w_err) begin
        if (r_err_cnt != {ERRW{1'b1}}) begin
          r_err_cnt <= r_err_cnt + ERRW'(1);
        end
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign VB_rec     = w_vb_rec;
  assign VC_rec     = w_vc_rec;
  assign TRB        = w_trb;
  assign TRC        = w_trc;
  assign rec_valid  = w_rec_valid;
  assign err        = r_err_p3;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;
endmodule

// File: tb/tb_isi_ms_decode.sv
// Directed testbench for isi_ms_decode (ENC_LAT=1, ERRW=4).
module tb_isi_ms_decode;
  localparam int ENC_LAT = 1;
  localparam int ERRW    = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [17:0]       SVB, STB;
  logic [5:0]        SVC, STC;
  logic signed [5:0] VB;
  logic signed [3:0] VC;
  logic              chk_en, clr;
  logic signed [5:0] VB_rec;
  logic signed [3:0] VC_rec;
  logic              rec_valid;
  logic [4:0]        TRB;
  logic [2:0]        TRC;
  logic              err;
  logic [ERRW-1:0]   err_cnt;
  logic              err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  isi_ms_decode #(.ENC_LAT(ENC_LAT), .ERRW(ERRW)) dut (
    .clk(clk), .rstn(rstn), .SVB(SVB), .STB(STB), .SVC(SVC), .STC(STC),
    .VB(VB), .VC(VC), .chk_en(chk_en), .clr(clr),
    .VB_rec(VB_rec), .VC_rec(VC_rec), .rec_valid(rec_valid), .TRB(TRB), .TRC(TRC),
    .err(err), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encoder model: |v| thermometer-selected elements, all signs set for v>=0, cleared for v<0.
  task automatic drive(input int bvec, input int cvec, input int bref, input int cref);
    int nb, nc;
    nb  = (bvec < 0) ? -bvec : bvec;
    nc  = (cvec < 0) ? -cvec : cvec;
    SVB = 18'((1 << nb) - 1);
    STB = (bvec >= 0) ? SVB : 18'h0;
    SVC = 6'((1 << nc) - 1);
    STC = (cvec >= 0) ? SVC : 6'h0;
    VB  = 6'(bref);
    VC  = 4'(cref);
  endtask

  task automatic test_reset();
    rstn = 1'b0; chk_en = 1'b0; clr = 1'b0;
    drive(0, 0, 0, 0);
    step(); step();
    n_checks++; if (VB_rec !== 6'sd0) begin n_fail++; $display("FAIL reset_vb_rec got=%0d exp=0", VB_rec); end
    n_checks++; if (VC_rec !== 4'sd0) begin n_fail++; $display("FAIL reset_vc_rec got=%0d exp=0", VC_rec); end
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rec_valid got=%b exp=0", rec_valid); end
    n_checks++; if (TRB !== 5'd0 || TRC !== 3'd0) begin n_fail++; $display("FAIL reset_tr got=%0d/%0d exp=0/0", TRB, TRC); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b/%0d/%b exp=0/0/0", err, err_cnt, err_sticky); end
  endtask

  task automatic test_plus18();
    rstn = 1'b1; chk_en = 1'b1;
    drive(18, 0, 18, 0);
    step();
    n_checks++; if (VB_rec !== 6'sd0) begin n_fail++; $display("FAIL p18_latency got=%0d exp=0", VB_rec); end
    step();
    n_checks++; if (VB_rec !== 6'sd18) begin n_fail++; $display("FAIL p18_vb_rec got=%0d exp=18", VB_rec); end
    n_checks++; if (TRB !== 5'd18 || TRC !== 3'd0) begin n_fail++; $display("FAIL p18_tr_first got=%0d/%0d exp=18/0", TRB, TRC); end
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL p18_rec_valid_early got=%b exp=0", rec_valid); end
    step();
    n_checks++; if (TRB !== 5'd0) begin n_fail++; $display("FAIL p18_tr_steady got=%0d exp=0", TRB); end
    n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL p18_rec_valid_c3 got=%b exp=1", rec_valid); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL p18_err got=%b exp=0", err); end
  endtask

  task automatic test_neg();
    chk_en = 1'b0;
    drive(-18, -6, -18, -6);
    step(); step();
    n_checks++; if (VB_rec !== 6'b101110) begin n_fail++; $display("FAIL neg_vb_rec got=%b exp=101110", VB_rec); end
    n_checks++; if (VC_rec !== 4'b1010) begin n_fail++; $display("FAIL neg_vc_rec got=%b exp=1010", VC_rec); end
    n_checks++; if (TRB !== 5'd18 || TRC !== 3'd6) begin n_fail++; $display("FAIL neg_tr got=%0d/%0d exp=18/6", TRB, TRC); end
    step();
    n_checks++; if (TRB !== 5'd0 || TRC !== 3'd0) begin n_fail++; $display("FAIL neg_tr_steady got=%0d/%0d exp=0/0", TRB, TRC); end
    step();
  endtask

  task automatic test_ramp();
    int pb, pc, vb, vc;
    pb = -18; pc = -6;
    chk_en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      vb = -18 + 3 * k;
      vc = -6 + k;
      drive(pb, pc, vb, vc);
      pb = vb; pc = vc;
      step();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ramp_err k=%0d got=%b exp=0", k, err); end
    end
    drive(pb, pc, pb, pc);
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ramp_tail_err k=%0d got=%b exp=0", k, err); end
    end
    n_checks++; if (VB_rec !== 6'sd18 || VC_rec !== 4'sd6) begin n_fail++; $display("FAIL ramp_final got=%0d/%0d exp=18/6", VB_rec, VC_rec); end
    n_checks++; if (err_cnt !== 4'd0 || rec_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_cnt got=%0d/%b exp=0/1", err_cnt, rec_valid); end
  endtask

  task automatic test_flip();
    STB = 18'h3FFFE;
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flip_err_a got=%b exp=0", err); end
    STB = 18'h3FFFF;
    step();
    n_checks++; if (VB_rec !== 6'sd16 || TRB !== 5'd1) begin n_fail++; $display("FAIL flip_rec got=%0d/%0d exp=16/1", VB_rec, TRB); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flip_err_b got=%b exp=0", err); end
    step();
    n_checks++; if (err !== 1'b1 || err_cnt !== 4'd1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL flip_err_c got=%b/%0d/%b exp=1/1/1", err, err_cnt, err_sticky); end
    step();
    n_checks++; if (err !== 1'b0 || err_cnt !== 4'd1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL flip_err_d got=%b/%0d/%b exp=0/1/1", err, err_cnt, err_sticky); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (err_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL flip_clr got=%0d/%b exp=0/0", err_cnt, err_sticky); end
  endtask

  task automatic test_saturate();
    VB = 6'sd5;
    for (int k = 0; k < 20; k++) step();
    n_checks++; if (err !== 1'b1 || err_cnt !== 4'd15 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sat_cnt got=%b/%0d/%b exp=1/15/1", err, err_cnt, err_sticky); end
    clr = 1'b1;
    step();
    n_checks++; if (err !== 1'b1 || err_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sat_clr_wins got=%b/%0d/%b exp=1/0/0", err, err_cnt, err_sticky); end
    clr = 1'b0;
    step();
    n_checks++; if (err_cnt !== 4'd1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sat_recount got=%0d/%b exp=1/1", err_cnt, err_sticky); end
    VB = 6'sd18;
    for (int k = 0; k < 5; k++) step();
    n_checks++; if (err !== 1'b0 || err_cnt !== 4'd4) begin
      n_fail++; $display("FAIL sat_recover got=%b/%0d exp=0/4", err, err_cnt); end
  endtask

  task automatic test_midreset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_checks++; if (VB_rec !== 6'sd0 || VC_rec !== 4'sd0 || TRB !== 5'd0 || TRC !== 3'd0) begin
      n_fail++; $display("FAIL mrst_data got=%0d/%0d/%0d/%0d exp=0/0/0/0", VB_rec, VC_rec, TRB, TRC); end
    n_checks++; if (rec_valid !== 1'b0 || err !== 1'b0 || err_cnt !== 4'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL mrst_ctrl got=%b/%b/%0d/%b exp=0/0/0/0", rec_valid, err, err_cnt, err_sticky); end
    step();
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid_c1 got=%b exp=0", rec_valid); end
    step();
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid_c2 got=%b exp=0", rec_valid); end
    n_checks++; if (VB_rec !== 6'sd18 || TRB !== 5'd18 || TRC !== 3'd6) begin
      n_fail++; $display("FAIL mrst_first got=%0d/%0d/%0d exp=18/18/6", VB_rec, TRB, TRC); end
    step();
    n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_valid_c3 got=%b exp=1", rec_valid); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mrst_err got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_plus18();
    test_neg();
    test_ramp();
    test_flip();
    test_saturate();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
